eink_phase_scanner: RTL
=======================

Name: eink_phase_scanner

Overview:
- Sequencer directly upstream of the waveform lookup stage.
- On a start pulse it walks every waveform phase, and within each phase every row and every 4-pixel column group.
- Per group it reads the packed {prev,new} pixel word from the framebuffer, presents it to the waveform lookup, captures the 8-bit drive code and hands it to the source-driver stage over a valid/ready handshake.
- It also owns phase/phase_type generation and the row/frame/done strobes.

Parameters:
COL_GROUPS, 200, 4-pixel groups per row (800 px)
ROWS, 600, rows per frame
ADDR_W, 17, framebuffer word address width; must hold ROWS*COL_GROUPS-1

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin an update; ignored unless idle
phase_type_in  in  2  update mode; 0=INIT, 1=DU, 2/3=GC4
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last group of the last phase is accepted
phase  out  7  current phase index to waveform stage
phase_type  out  2  latched mode to waveform stage
phase_count  in  7  phase count from waveform stage (combinational on phase_type)
fb_addr  out  ADDR_W  framebuffer word address
fb_rd  out  1  read strobe; fb_rdata valid exactly 1 cycle later
fb_rdata  in  16  {prev[15:8], new[7:0]}
fb_wr  out  1  write strobe (optional feature)
fb_wdata  out  16  write data (optional feature)
wf_data_in  out  16  registered pixel word to waveform stage
wf_data_out  in  8  drive code from waveform stage
src_data  out  8  drive code to source-driver stage
src_valid  out  1  src_data valid
src_ready  in  1  source-driver stage accepts when valid&ready
row_end  out  1  one-cycle pulse after last group of each row accepted
frame_start  out  1  one-cycle pulse at start of each phase

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; phase, row, col and address counters 0.
- IDLE: on start, latch phase_type<=phase_type_in, busy<=1, phase<=0, go to SETUP.
- SETUP (1 cycle): waveform stage registers its ROM word off phase. frame_start=1; clear row, col, fb_addr.
  - If phase_count==0, skip directly to DONE.
- FETCH (1 cycle): fb_rd=1 with fb_addr.
- LATCH (1 cycle): wf_data_in<=fb_rdata.
- EMIT: on entry src_data<=wf_data_out (sampled in the first EMIT cycle) and src_valid<=1. Hold both stable until src_ready.
  - On src_valid&src_ready: src_valid<=0; fb_addr+1; col+1.
  - If col was COL_GROUPS-1: col<=0, go to ROW_END; else go to FETCH.
- ROW_END (1 cycle): row_end=1.
  - Row not last: row+1, go to FETCH.
  - Row last, phase<phase_count-1: phase+1, go to SETUP.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy<=0, go to IDLE.
- Throughput: 3 cycles per group minimum (FETCH, LATCH, EMIT with ready high).
- start while busy: ignored; phase_type_in changes while busy: ignored.
- src_ready high before src_valid: no effect.
- fb_addr: increments linearly, never exceeds ROWS*COL_GROUPS-1, returns to 0 at each SETUP.
- Async reset mid-update: immediate return to IDLE with all outputs 0. No done pulse, no pending write.

Optional Feature:
Macro: PHASE_WRITEBACK_EN
- Defined: in the last phase (phase==phase_count-1), in the first EMIT cycle of each group, fb_wr=1 for exactly one cycle, fb_addr = current group, fb_wdata={wf_data_in[7:0], wf_data_in[7:0]}. Result: new pixels become prev for the next update. Write occurs regardless of src_ready.
- Not defined: fb_wr and fb_wdata tied 0; framebuffer untouched.

Test Plan:
- Reset mid-EMIT (src_ready=0) -> next cycle busy=0, src_valid=0, fb_rd=0, phase=0; later start runs normally from phase 0.
- COL_GROUPS=2, ROWS=2, phase_count=3, src_ready=1 -> 12 src_valid beats, 6 row_end, 3 frame_start, phase 0,1,2, one done; fb_addr sequence 0..3 repeated three times.
- fb_rdata=16'h55AA at addr 0 -> wf_data_in=16'h55AA one cycle after fb_rd; src_data equals model of wf_data_out for that word.
- src_ready low 5 cycles in EMIT -> src_data and src_valid stable 6 cycles; no fb_rd and no address advance until the handshake.
- start pulsed while busy; phase_count=0 -> busy start ignored; a zero-count start gives frame_start, then done 2 cycles after start, with no fb_rd.
- PHASE_WRITEBACK_EN, phase_count=2, fb_rdata=16'h1B E4 -> fb_wr only in phase 1, fb_wdata=16'hE4E4, one write per group.

Source files
------------

// File: rtl/eink_phase_scanner.sv
// E-ink phase scanner: walks phases x rows x column groups, feeding framebuffer words to the
// waveform lookup and its drive codes to the source driver. Optional macro: PHASE_WRITEBACK_EN.
//
// state   | meaning
// IDLE    | waiting for start
// SETUP   | waveform stage loads phase ROM word; counters cleared; frame_start
// FETCH   | fb_rd issued for current group
// LATCH   | framebuffer word captured into wf_data_in
// EMIT    | drive code offered to source driver until accepted
// ROW_END | row_end strobe; advance row or phase
// DONE    | done strobe; busy drops
module eink_phase_scanner #(
  parameter int COL_GROUPS = 200,
  parameter int ROWS       = 600,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        phase_type_in,
  output logic              busy,
  output logic              done,
  output logic [6:0]        phase,
  output logic [1:0]        phase_type,
  input  logic [6:0]        phase_count,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [15:0]       fb_rdata,
  output logic              fb_wr,
  output logic [15:0]       fb_wdata,
  output logic [15:0]       wf_data_in,
  input  logic [7:0]        wf_data_out,
  output logic [7:0]        src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              row_end,
  output logic              frame_start
);

  localparam int COL_W = (COL_GROUPS > 1) ? $clog2(COL_GROUPS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_GROUPS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_ROW_END = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             emit_first;
  logic [7:0]       src_data_q;
  logic             col_last;
  logic             row_last;
  logic             phase_more;
  logic             handshake;

  assign col_last   = (col == COL_LAST);
  assign row_last   = (row == ROW_LAST);
  assign phase_more = (({1'b0, phase} + 8'd1) < {1'b0, phase_count});
  assign handshake  = (state == S_EMIT) && src_valid && src_ready;

  assign frame_start = (state == S_SETUP);
  assign fb_rd       = (state == S_FETCH);
  assign row_end     = (state == S_ROW_END);
  assign done        = (state == S_DONE);

  // The lookup result is offered live in the first EMIT cycle so a group can
  // complete in 3 cycles; the captured copy holds it stable afterwards.
  assign src_data = emit_first ? wf_data_out : src_data_q;

`ifdef PHASE_WRITEBACK_EN
  logic phase_last;
  assign phase_last = (({1'b0, phase} + 8'd1) == {1'b0, phase_count});
  assign fb_wr      = emit_first && phase_last;
  assign fb_wdata   = fb_wr ? {wf_data_in[7:0], wf_data_in[7:0]} : 16'h0000;
`else
  assign fb_wr    = 1'b0;
  assign fb_wdata = 16'h0000;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      phase      <= 7'd0;
      phase_type <= 2'd0;
      fb_addr    <= '0;
      col        <= '0;
      row        <= '0;
      wf_data_in <= 16'h0000;
      src_valid  <= 1'b0;
      src_data_q <= 8'h00;
      emit_first <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            phase_type <= phase_type_in;
            busy       <= 1'b1;
            phase      <= 7'd0;
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          row     <= '0;
          col     <= '0;
          fb_addr <= '0;
          state   <= (phase_count == 7'd0) ? S_DONE : S_FETCH;
        end
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          wf_data_in <= fb_rdata;
          src_valid  <= 1'b1;
          emit_first <= 1'b1;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          emit_first <= 1'b0;
          if (emit_first) begin
            src_data_q <= wf_data_out;
          end
          if (handshake) begin
            src_valid <= 1'b0;
            // Hold on the final group so the address never leaves the frame.
            if (!(col_last && row_last)) begin
              fb_addr <= fb_addr + ADDR_W'(1);
            end
            if (col_last) begin
              col   <= '0;
              state <= S_ROW_END;
            end else begin
              col   <= col + COL_W'(1);
              state <= S_FETCH;
            end
          end
        end
        S_ROW_END: begin
          if (!row_last) begin
            row   <= row + ROW_W'(1);
            state <= S_FETCH;
          end else if (phase_more) begin
            phase <= phase + 7'd1;
            state <= S_SETUP;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
